// File: rtl/uart_pkt_pkg.sv
// Shared types for the UART packet controller: FSM state encoding,
// error codes and the default frame-start marker.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// Signal bundle between the UART byte source (master) and the packet
// controller (slave), including the register-bank write port it drives.
interface uart_rx_pkt_ctrl_if #(
    parameter int ADDR_W = 8
);
    // rbyte_ready is a one-cycle valid strobe qualifying rx_byte; there is no
    // ready/backpressure path, so the controller must accept or drop every byte.
    logic [7:0]        rx_byte;
    logic              rbyte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              pkt_ok;
    logic              pkt_err;
    logic [1:0]        err_code;
    logic              busy;

    modport master (
        output rx_byte, rbyte_ready,
        input  wr_en, wr_addr, wr_data, pkt_ok, pkt_err, err_code, busy
    );

    modport slave (
        input  rx_byte, rbyte_ready,
        output wr_en, wr_addr, wr_data, pkt_ok, pkt_err, err_code, busy
    );

endinterface

// File: rtl/uart_pkt_timeout.sv
// Inter-byte timeout: down-counter reloaded by clr_i or while disabled,
// expire_o is high in the cycle the count reaches zero while enabled.
module uart_pkt_timeout #(
    parameter int CLKS = 104160
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int             CW     = $clog2(CLKS + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reloading to CLKS-1 makes expiry land exactly CLKS cycles after the last byte.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART bytes (SYNC, ADDR, LEN, DATA.., CHK) into packets and replays
// verified payloads as a write burst. Optional inter-byte timeout: UART_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int         ADDR_W       = 8,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 104160
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rbyte_ready_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              pkt_ok_o,
    output logic              pkt_err_o,
    output logic [1:0]        err_code_o,
    output logic              busy_o,
    output logic [2:0]        dbg_state_o
);
    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              pkt_err_q, pkt_err_d;
    logic              buf_we;
    logic [7:0]        buf_q [MAX_LEN];
    logic              timeout_hit;
    logic              drain;

`ifdef UART_PKT_TIMEOUT_EN
    logic to_run;
    assign to_run = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CHK);

    uart_pkt_timeout #(
        .CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (rbyte_ready_i),
        .en_i     (to_run),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        err_code_d = err_code_q;
        pkt_err_d  = 1'b0;
        buf_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rbyte_ready_i && rx_byte_i == SYNC_BYTE) begin
                    state_d = ST_ADDR;
                    sum_d   = 8'd0;
                end
            end
            ST_ADDR: begin
                if (rbyte_ready_i) begin
                    addr_d  = ADDR_W'(rx_byte_i);
                    sum_d   = sum_q + rx_byte_i;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rbyte_ready_i) begin
                    if (rx_byte_i == 8'd0 || rx_byte_i > MAX_LEN_B) begin
                        err_code_d = ERR_LEN;
                        pkt_err_d  = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        len_d   = rx_byte_i;
                        idx_d   = 8'd0;
                        sum_d   = sum_q + rx_byte_i;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rbyte_ready_i) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + rx_byte_i;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q + 8'd1 == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rbyte_ready_i) begin
                    if (rx_byte_i == sum_q) begin
                        idx_d   = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        err_code_d = ERR_CHK;
                        pkt_err_d  = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                // Incoming bytes are dropped here; idx walks the buffer one per clock.
                idx_d = idx_q + 8'd1;
                if (idx_q == len_q - 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) begin
            err_code_d = ERR_TIMEOUT;
            pkt_err_d  = 1'b1;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            sum_q      <= 8'd0;
            err_code_q <= ERR_NONE;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            err_code_q <= err_code_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    // Payload storage needs no reset: it is always written before it is read.
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            buf_q[idx_q[IDX_W-1:0]] <= rx_byte_i;
        end
    end

    assign drain       = (state_q == ST_DRAIN);
    assign wr_en_o     = drain;
    assign wr_addr_o   = drain ? (addr_q + ADDR_W'(idx_q)) : '0;
    assign wr_data_o   = drain ? buf_q[idx_q[IDX_W-1:0]] : 8'd0;
    assign pkt_ok_o    = drain && (idx_q == len_q - 8'd1);
    assign pkt_err_o   = pkt_err_q;
    assign err_code_o  = err_code_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Randomized bench for uart_rx_pkt_ctrl: frames are built from the packet
// rules and their expected writes/errors queued for a negedge monitor.
module tb_uart_rx_pkt_ctrl;
    import uart_pkt_pkg::*;

    localparam int         ADDR_W  = 8;
    localparam int         MAX_LEN = 16;
    localparam int         TO      = 200;
    localparam logic [7:0] SYNC    = 8'hA5;

    // clock / reset
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_rx_pkt_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();
    logic [2:0] dbg_state;

    uart_rx_pkt_ctrl #(
        .ADDR_W       (ADDR_W),
        .MAX_LEN      (MAX_LEN),
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .rx_byte_i     (ifc.rx_byte),
        .rbyte_ready_i (ifc.rbyte_ready),
        .wr_en_o       (ifc.wr_en),
        .wr_addr_o     (ifc.wr_addr),
        .wr_data_o     (ifc.wr_data),
        .pkt_ok_o      (ifc.pkt_ok),
        .pkt_err_o     (ifc.pkt_err),
        .err_code_o    (ifc.err_code),
        .busy_o        (ifc.busy),
        .dbg_state_o   (dbg_state)
    );

    // scoreboard state
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [ADDR_W+7:0] exp_q[$];
    int                exp_len_q[$];
    int                ok_cnt = 0, err_cnt = 0, run_len = 0;
    int                exp_ok = 0, exp_err = 0;
    logic [1:0]        exp_code = 2'b00;
    logic [ADDR_W+7:0] mon_e;
    int                mon_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (ifc.wr_en) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'(ifc.wr_en), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr_data", 32'({ifc.wr_addr, ifc.wr_data}), 32'(mon_e));
                end
            end
            if (ifc.pkt_ok) begin
                ok_cnt++;
                check("ok_with_wr", 32'(ifc.wr_en), 32'd1);
                mon_len = (exp_len_q.size() != 0) ? exp_len_q.pop_front() : 0;
                check("burst_len", 32'(run_len), 32'(mon_len));
                run_len = 0;
            end
            if (ifc.pkt_err) err_cnt++;
        end
    end

    // drivers
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        ifc.rx_byte     = b;
        ifc.rbyte_ready = 1'b1;
        @(negedge clk);
        ifc.rbyte_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h00;
            send_byte(b, $urandom_range(0, 2));
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            if (!ifc.busy) break;
            @(negedge clk);
        end
        if (k == 200) check(tag, 32'(ifc.busy), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        exp_code = ERR_NONE;
    endtask

    task automatic end_frame(input string tag);
        wait_idle({tag, "_idle"});
        repeat (2) @(negedge clk);
        check({tag, "_ok_cnt"},   32'(ok_cnt),          32'(exp_ok));
        check({tag, "_err_cnt"},  32'(err_cnt),         32'(exp_err));
        check({tag, "_err_code"}, 32'(ifc.err_code),    32'(exp_code));
        check({tag, "_pending"},  32'(exp_q.size()),    32'd0);
        check({tag, "_busy"},     32'(ifc.busy),        32'd0);
    endtask

    // reference model: frame-level rules applied directly to the byte list
    task automatic send_frame(input string tag, input logic [7:0] addr, input int len,
                              input logic [7:0] data[$], input bit corrupt,
                              input int gapmax, input bit poke);
        int         s;
        logic [7:0] chk;
        bit         good;
        s = int'(addr) + len;
        foreach (data[i]) s += int'(data[i]);
        chk = 8'(s % 256);
        if (corrupt) chk = 8'((int'(chk) + $urandom_range(1, 255)) % 256);
        good = 1'b0;
        if (len == 0 || len > MAX_LEN) begin
            exp_err++;
            exp_code = ERR_LEN;
        end else if (corrupt) begin
            exp_err++;
            exp_code = ERR_CHK;
        end else begin
            good = 1'b1;
            exp_ok++;
            for (int i = 0; i < len; i++)
                exp_q.push_back({8'((int'(addr) + i) % 256), data[i]});
            exp_len_q.push_back(len);
        end
        send_byte(SYNC, $urandom_range(0, gapmax));
        send_byte(addr, $urandom_range(0, gapmax));
        send_byte(8'(len), $urandom_range(0, gapmax));
        if (len != 0 && len <= MAX_LEN) begin
            for (int i = 0; i < len; i++) send_byte(data[i], $urandom_range(0, gapmax));
            send_byte(chk, 0);
            if (good) begin
                check({tag, "_wr_latency"}, 32'(ifc.wr_en), 32'd1);
                if (poke && len >= 3) send_byte(8'($urandom_range(0, 255)), 0);
            end
        end
        end_frame(tag);
    endtask

    logic [7:0] d[$];
    logic [7:0] chk_b;
    int         s_b;
    int         len_r;

    initial begin
        ifc.rx_byte     = 8'h00;
        ifc.rbyte_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en",    32'(ifc.wr_en),    32'd0);
        check("rst_wr_addr",  32'(ifc.wr_addr),  32'd0);
        check("rst_wr_data",  32'(ifc.wr_data),  32'd0);
        check("rst_pkt_ok",   32'(ifc.pkt_ok),   32'd0);
        check("rst_pkt_err",  32'(ifc.pkt_err),  32'd0);
        check("rst_err_code", 32'(ifc.err_code), 32'd0);
        check("rst_busy",     32'(ifc.busy),     32'd0);
        check("rst_state",    32'(dbg_state),    32'(ST_IDLE));
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        d = {8'h11, 8'h22, 8'h33};
        send_frame("t1_basic", 8'h10, 3, d, 1'b0, 0, 1'b0);
        send_frame("t2_badchk", 8'h10, 3, d, 1'b1, 0, 1'b0);
        d.delete();
        send_frame("t3_len0", 8'h20, 0, d, 1'b0, 0, 1'b0);
        send_frame("t3_len17", 8'h20, 17, d, 1'b0, 0, 1'b0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        d = {8'hAA, 8'hBB};
        send_frame("t4_wrap", 8'hFE, 2, d, 1'b0, 1, 1'b0);
        d = {SYNC, SYNC, 8'h01};
        send_frame("t_sync_in_data", SYNC, 3, d, 1'b0, 1, 1'b1);

        // inter-byte silence after ADDR
        send_byte(SYNC, 0);
        send_byte(8'h10, 0);
        repeat (TO - 10) @(negedge clk);
        check("t5_busy_early", 32'(ifc.busy), 32'd1);
`ifdef UART_PKT_TIMEOUT_EN
        exp_err++;
        exp_code = ERR_TIMEOUT;
        end_frame("t5_timeout");
`else
        repeat (2 * TO) @(negedge clk);
        check("t5_busy_wait", 32'(ifc.busy),     32'd1);
        check("t5_no_err",    32'(err_cnt),      32'(exp_err));
        check("t5_code",      32'(ifc.err_code), 32'(exp_code));
        pulse_reset();
        check("t5_rst_code",  32'(ifc.err_code), 32'd0);
`endif

        // reset in the middle of a 4-byte burst
        d = {8'h01, 8'h02, 8'h03, 8'h04};
        s_b = 8'h40 + 4 + 1 + 2 + 3 + 4;
        chk_b = 8'(s_b % 256);
        for (int i = 0; i < 4; i++) exp_q.push_back({8'(8'h40 + i), d[i]});
        exp_len_q.push_back(4);
        send_byte(SYNC, 0);
        send_byte(8'h40, 0);
        send_byte(8'd4, 0);
        for (int i = 0; i < 4; i++) send_byte(d[i], 0);
        send_byte(chk_b, 0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t6_wr_en_drop", 32'(ifc.wr_en),     32'd0);
        check("t6_no_ok",      32'(ifc.pkt_ok),    32'd0);
        check("t6_busy",       32'(ifc.busy),      32'd0);
        check("t6_writes",     32'(exp_q.size()),  32'd2);
        exp_q.delete();
        exp_len_q.delete();
        run_len  = 0;
        exp_code = ERR_NONE;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check("t6_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
        d = {8'h5A, 8'hC3, 8'h00};
        send_frame("t6_after", 8'h80, 3, d, 1'b0, 1, 1'b0);

        for (int f = 0; f < 40; f++) begin
            send_junk($urandom_range(0, 3));
            len_r = $urandom_range(0, 18);
            d.delete();
            for (int i = 0; i < len_r; i++)
                d.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255)));
            send_frame("rnd", 8'($urandom_range(0, 255)), len_r, d,
                       $urandom_range(0, 5) == 0, 3, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
